// File: rtl/pyr_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pyr_pkg : shared widths and types for the image pyramid stages
// Revision: 1.0
// ----------------------------------------------------------------------------
package pyr_pkg;
  localparam int PYR_PIX_W  = 8;
  localparam int PYR_SUM2_W = PYR_PIX_W + 1;
  localparam int PYR_SUM4_W = PYR_PIX_W + 2;
  localparam int PYR_RND    = 2;

  typedef logic [PYR_PIX_W-1:0]  pix_t;
  typedef logic [PYR_SUM2_W-1:0] sum2_t;
  typedef logic [PYR_SUM4_W-1:0] sum4_t;
endpackage
`default_nettype wire

// File: rtl/pyr_line_buf.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pyr_line_buf : simple dual-port RAM, one write port, 1-cycle synchronous read
// Revision: 1.0
// ----------------------------------------------------------------------------
module pyr_line_buf
  import pyr_pkg::*;
#(
  parameter int DEPTH = 320,
  parameter int WIDTH = 9,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data;

  // Read data holds between reads so the consumer may stall.
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/pyr_downsample_2x.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pyr_downsample_2x : streaming 2x2 box-filter decimator (level N -> N+1)
// Revision: 1.0
// ----------------------------------------------------------------------------
module pyr_downsample_2x
  import pyr_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int PIX_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_pix,
  input  logic             in_sof,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_pix,
  output logic             out_sof,
  output logic             out_eol,
  output logic             frame_done
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int LB_D  = IMG_W / 2;
  localparam int LB_AW = $clog2(LB_D);
  localparam logic [COL_W-1:0] c_COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] c_ROW_LAST = ROW_W'(IMG_H - 1);

  logic [COL_W-1:0] r_col, w_col;
  logic [ROW_W-1:0] r_row, w_row;
  logic             r_synced;
  logic [PIX_W-1:0] r_pair;
  logic             r_out_valid, r_out_sof, r_out_eol, r_frame_done;
  logic [PIX_W-1:0] r_out_pix;
  logic [PIX_W:0]   w_sum2, w_lb_rd;
  logic [PIX_W+1:0] w_sum4;
  logic [LB_AW-1:0] w_lb_addr;
  logic w_accept, w_active, w_col_last, w_row_last, w_lb_wr, w_lb_rd_en, w_load;

  assign in_ready   = ~(r_out_valid & ~out_ready);
  assign w_accept   = in_valid & in_ready;
  // Unsynced pixels are accepted but have no effect until an in_sof arrives.
  assign w_active   = w_accept & (in_sof | r_synced);
  assign w_col      = in_sof ? '0 : r_col;
  assign w_row      = in_sof ? '0 : r_row;
  assign w_col_last = (w_col == c_COL_LAST);
  assign w_row_last = (w_row == c_ROW_LAST);
  assign w_lb_addr  = w_col[COL_W-1:1];
  assign w_sum2     = {1'b0, r_pair} + {1'b0, in_pix};
  assign w_lb_wr    = w_active & ~w_row[0] & w_col[0];
  assign w_lb_rd_en = w_active & w_row[0] & ~w_col[0];
  assign w_load     = w_active & w_row[0] & w_col[0];
  assign w_sum4     = {1'b0, w_lb_rd} + {1'b0, w_sum2} + (PIX_W+2)'(PYR_RND);

  pyr_line_buf #(
    .DEPTH (LB_D),
    .WIDTH (PIX_W + 1),
    .AW    (LB_AW)
  ) u_line_buf (
    .clk       (clk),
    .i_wr_en   (w_lb_wr),
    .i_wr_addr (w_lb_addr),
    .i_wr_data (w_sum2),
    .i_rd_en   (w_lb_rd_en),
    .i_rd_addr (w_lb_addr),
    .o_rd_data (w_lb_rd)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_col        <= '0;
      r_row        <= '0;
      r_synced     <= 1'b0;
      r_pair       <= '0;
      r_out_valid  <= 1'b0;
      r_out_pix    <= '0;
      r_out_sof    <= 1'b0;
      r_out_eol    <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (r_out_valid & out_ready) r_out_valid <= 1'b0;
      if (w_active) begin
        if (!w_col[0]) r_pair <= in_pix;
        if (w_col_last) begin
          r_col <= '0;
          if (w_row_last) begin
            r_row        <= '0;
            r_synced     <= 1'b0;
            r_frame_done <= 1'b1;
          end else begin
            r_row    <= w_row + 1'b1;
            r_synced <= 1'b1;
          end
        end else begin
          r_col    <= w_col + 1'b1;
          r_row    <= w_row;
          r_synced <= 1'b1;
        end
      end
      // A load can coincide with an output transfer, keeping out_valid high.
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_pix   <= w_sum4[PIX_W+1:2];
        r_out_sof   <= (w_row == ROW_W'(1)) && (w_col == COL_W'(1));
        r_out_eol   <= w_col_last;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_pix    = r_out_pix;
  assign out_sof    = r_out_sof;
  assign out_eol    = r_out_eol;
  assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_pyr_downsample_2x.sv
`default_nettype none
// Bench for pyr_downsample_2x: 4x4 main instance plus a 4x3 odd-height instance.
module tb_pyr_downsample_2x;
  localparam int W = 4;
  localparam int H = 4;

  typedef logic [3:0][3:0][7:0] frame_t;  // [block][tl,tr,bl,br]
  typedef struct packed {
    logic [3:0][7:0] px;
    logic [7:0]      exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic in_valid = 1'b0, in_valid3 = 1'b0, in_sof = 1'b0;
  logic [7:0] in_pix = '0;
  logic out_ready = 1'b1, out_ready3 = 1'b1;
  logic in_ready, out_valid, out_sof, out_eol, frame_done;
  logic in_ready3, out_valid3, out_sof3, out_eol3, frame_done3;
  logic [7:0] out_pix, out_pix3;

  always #5 clk = ~clk;

  pyr_downsample_2x #(.IMG_W(W), .IMG_H(H), .PIX_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_pix(in_pix), .in_sof(in_sof), .out_valid(out_valid), .out_ready(out_ready),
    .out_pix(out_pix), .out_sof(out_sof), .out_eol(out_eol), .frame_done(frame_done));

  pyr_downsample_2x #(.IMG_W(W), .IMG_H(3), .PIX_W(8)) dut3 (
    .clk(clk), .reset(reset), .in_valid(in_valid3), .in_ready(in_ready3),
    .in_pix(in_pix), .in_sof(in_sof), .out_valid(out_valid3), .out_ready(out_ready3),
    .out_pix(out_pix3), .out_sof(out_sof3), .out_eol(out_eol3), .frame_done(frame_done3));

  int checks = 0, errors = 0;
  int acc_cnt = 0, fd_cnt = 0, fd_at = 0, acc3 = 0, fd3_cnt = 0, fd3_at = 0;
  logic [9:0] q[$];
  logic [9:0] q3[$];

  always @(negedge clk) begin
    if (frame_done) begin fd_cnt++; fd_at = acc_cnt; end
    if (frame_done3) begin fd3_cnt++; fd3_at = acc3; end
    if (in_valid && in_ready) acc_cnt++;
    if (in_valid3 && in_ready3) acc3++;
    if (out_valid && out_ready) q.push_back({out_sof, out_eol, out_pix});
    if (out_valid3 && out_ready3) q3.push_back({out_sof3, out_eol3, out_pix3});
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_out(input bit h3, input string nm, input int i, input int pix,
                         input int sof, input int eol);
    logic [9:0] e;
    int sz;
    sz = h3 ? q3.size() : q.size();
    if (i >= sz) begin
      checks++; errors++;
      $display("FAIL %s_out%0d: got no output expected pix %0d", nm, i, pix);
    end else begin
      e = h3 ? q3[i] : q[i];
      chk($sformatf("%s_out%0d_pix", nm, i), int'(e[7:0]), pix);
      chk($sformatf("%s_out%0d_sof", nm, i), int'(e[9]), sof);
      chk($sformatf("%s_out%0d_eol", nm, i), int'(e[8]), eol);
    end
  endtask

  task automatic send(input bit h3, input logic [7:0] p, input bit sof);
    bit acc;
    int n;
    n = 0;
    in_pix = p; in_sof = sof;
    if (h3) in_valid3 = 1'b1; else in_valid = 1'b1;
    do begin
      @(negedge clk);
      acc = h3 ? in_ready3 : in_ready;
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 300);
    in_valid = 1'b0; in_valid3 = 1'b0; in_sof = 1'b0;
    if (!acc) begin
      checks++; errors++;
      $display("FAIL send_timeout: got in_ready 0 expected 1 within 300 cycles");
    end
  endtask

  task automatic send_frame(input bit h3, input frame_t b, input int rows, input bit sof);
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < W; c++)
        send(h3, b[((r >> 1) & 1) * 2 + (c >> 1)][(r & 1) * 2 + (c & 1)],
             sof && r == 0 && c == 0);
  endtask

  function automatic frame_t const_frame(input logic [7:0] a, b, c, d);
    frame_t f;
    for (int j = 0; j < 4; j++) begin
      f[0][j] = a; f[1][j] = b; f[2][j] = c; f[3][j] = d;
    end
    return f;
  endfunction

  function automatic vec_t mk(input logic [7:0] tl, tr, bl, br, e);
    vec_t v;
    v.px[0] = tl; v.px[1] = tr; v.px[2] = bl; v.px[3] = br; v.exp = e;
    return v;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish within 500us");
    $fatal(1);
  end

  initial begin
    vec_t tv[8];
    frame_t fr;
    int base, fd0, n, held, bad_rdy, bad_hold, bad_vld;

    tv[0] = mk(1, 2, 2, 2, 2);
    tv[1] = mk(255, 255, 255, 255, 255);
    tv[2] = mk(0, 0, 0, 1, 0);
    tv[3] = mk(0, 0, 1, 1, 1);
    tv[4] = mk(10, 20, 30, 40, 25);
    tv[5] = mk(3, 3, 3, 4, 3);
    tv[6] = mk(0, 0, 0, 2, 1);
    tv[7] = mk(254, 255, 255, 255, 255);

    // Reset state
    idle(3);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid3", out_valid3, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    idle(1);

    // Constant frame
    q.delete(); base = acc_cnt; fd0 = fd_cnt;
    send_frame(0, const_frame(100, 100, 100, 100), H, 1);
    idle(4);
    chk("const_count", q.size(), 4);
    for (int k = 0; k < 4; k++) chk_out(0, "const", k, 100, k == 0, k % 2);
    chk("const_fd_pulses", fd_cnt - fd0, 1);
    chk("const_fd_at", fd_at - base, 16);

    // Table-driven rounding frames
    for (int f = 0; f < 2; f++) begin
      q.delete();
      for (int k = 0; k < 4; k++) fr[k] = tv[f * 4 + k].px;
      send_frame(0, fr, H, 1);
      idle(4);
      chk($sformatf("tbl%0d_count", f), q.size(), 4);
      for (int k = 0; k < 4; k++)
        chk_out(0, $sformatf("tbl%0d", f), k, tv[f * 4 + k].exp, k == 0, k % 2);
    end

    // Backpressure
    q.delete(); bad_rdy = 0; bad_hold = 0; bad_vld = 0; held = 0; n = 0;
    fork
      send_frame(0, const_frame(10, 20, 30, 40), H, 1);
      begin
        do begin @(posedge clk); #1; n++; end while (!out_valid && n < 100);
        out_ready = 1'b0;
        held = out_pix;
        repeat (10) begin
          @(negedge clk);
          if (in_ready) bad_rdy++;
          if (!out_valid) bad_vld++;
          if (out_pix !== 8'(held)) bad_hold++;
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    idle(4);
    chk("bp_first_seen", int'(n < 100), 1);
    chk("bp_held_value", held, 10);
    chk("bp_in_ready_high_cycles", bad_rdy, 0);
    chk("bp_out_valid_low_cycles", bad_vld, 0);
    chk("bp_pix_changes", bad_hold, 0);
    chk("bp_count", q.size(), 4);
    for (int k = 0; k < 4; k++) chk_out(0, "bp", k, 10 * (k + 1), k == 0, k % 2);

    // Pre-sync drop, then resync with in_sof arriving at row 2
    q.delete(); fd0 = fd_cnt;
    for (int i = 0; i < 5; i++) send(0, 99, 0);
    idle(4);
    chk("presync_count", q.size(), 0);
    for (int i = 0; i < 9; i++) send(0, 200, i == 0);
    send_frame(0, const_frame(11, 22, 33, 44), H, 1);
    idle(4);
    chk("resync_count", q.size(), 6);
    chk_out(0, "resync_old", 0, 200, 1, 0);
    chk_out(0, "resync_old", 1, 200, 0, 1);
    for (int k = 0; k < 4; k++) chk_out(0, "resync_new", k + 2, 11 * (k + 1), k == 0, k % 2);
    chk("resync_fd_pulses", fd_cnt - fd0, 1);

    // Reset asserted alongside input pixel 9
    for (int i = 0; i < 8; i++) send(0, 60, i == 0);
    in_pix = 60; in_valid = 1'b1; reset = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_frame_done", frame_done, 0);
    reset = 1'b1;
    idle(1);
    q.delete(); fd0 = fd_cnt;
    for (int i = 0; i < 3; i++) send(0, 77, 0);
    send_frame(0, const_frame(5, 6, 7, 8), H, 1);
    idle(4);
    chk("midrst_count", q.size(), 4);
    for (int k = 0; k < 4; k++) chk_out(0, "midrst", k, 5 + k, k == 0, k % 2);
    chk("midrst_fd_pulses", fd_cnt - fd0, 1);

    // Odd height (IMG_H=3): rows 10, 30, 250
    q.delete(); q3.delete(); base = acc3; fd0 = fd3_cnt;
    for (int k = 0; k < 2; k++) begin
      fr[k][0] = 10; fr[k][1] = 10; fr[k][2] = 30; fr[k][3] = 30;
      fr[k + 2][0] = 250; fr[k + 2][1] = 250; fr[k + 2][2] = 0; fr[k + 2][3] = 0;
    end
    send_frame(1, fr, 3, 1);
    idle(4);
    chk("odd_count", q3.size(), 2);
    chk_out(1, "odd", 0, 20, 1, 0);
    chk_out(1, "odd", 1, 20, 0, 1);
    chk("odd_fd_pulses", fd3_cnt - fd0, 1);
    chk("odd_fd_at", fd3_at - base, 12);
    chk("odd_main_quiet", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
